// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider controller for DIV/DIVU.
// Stalls EX while dividing and produces one HI (remainder) / LO (quotient) write.
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             annul_i,
  output logic             stall_o,
  output logic             done_o,
  output logic             hilo_en_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {S_IDLE, S_ZERO, S_BUSY, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] rem_reg, quo_reg, dvs_reg, dvd_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             neg_q_reg, neg_r_reg;

  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH-1:0] rem_shift, rem_step, quo_step;
  logic [WIDTH:0]   diff;
  logic             no_borrow;

  assign accept    = start_i & ~annul_i;
  assign last_step = (cnt_reg == LAST_CNT);

  assign dvd_abs = (signed_i & dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
  assign dvs_abs = (signed_i & divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

  // One restoring step; the bit shifted out of rem counts as a guaranteed no-borrow.
  assign rem_shift = {rem_reg[WIDTH-2:0], quo_reg[WIDTH-1]};
  assign diff      = {1'b0, rem_shift} - {1'b0, dvs_reg};
  assign no_borrow = rem_reg[WIDTH-1] | ~diff[WIDTH];
  assign rem_step  = no_borrow ? diff[WIDTH-1:0] : rem_shift;
  assign quo_step  = {quo_reg[WIDTH-2:0], no_borrow};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = (divisor_i == '0) ? S_ZERO : S_BUSY;
        end
      end
      S_ZERO: state_next = annul_i ? S_IDLE : S_DONE;
      S_BUSY: begin
        if (annul_i) begin
          state_next = S_IDLE;
        end else if (last_step) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall_o   = 1'b0;
    done_o    = 1'b0;
    hilo_en_o = 1'b0;
    case (state_reg)
      S_IDLE: stall_o = accept;
      S_ZERO: stall_o = 1'b1;
      S_BUSY: stall_o = 1'b1;
      S_DONE: begin
        done_o    = ~annul_i;
        hilo_en_o = ~annul_i;
      end
      default: ;
    endcase
  end

  // Datapath; hi/lo only change on a transition into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      dvs_reg   <= '0;
      dvd_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            cnt_reg   <= '0;
            rem_reg   <= '0;
            quo_reg   <= dvd_abs;
            dvs_reg   <= dvs_abs;
            dvd_reg   <= dividend_i;
            neg_q_reg <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
            neg_r_reg <= signed_i & dividend_i[WIDTH-1];
          end
        end
        S_ZERO: begin
          if (!annul_i) begin
            hi_reg <= dvd_reg;
            lo_reg <= '1;
          end
        end
        S_BUSY: begin
          rem_reg <= rem_step;
          quo_reg <= quo_step;
          cnt_reg <= cnt_reg + 1'b1;
          if (last_step && !annul_i) begin
            hi_reg <= neg_r_reg ? -rem_step : rem_step;
            lo_reg <= neg_q_reg ? -quo_step : quo_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_o = hi_reg;
  assign lo_o = lo_reg;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, results, annul, reset and back-to-back.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        annul_i;
  logic        stall_o;
  logic        done_o;
  logic        hilo_en_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int tests = 0;
  int fails = 0;
  int pulses;

  always #5 clk = ~clk;

  div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .annul_i    (annul_i),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .hilo_en_o  (hilo_en_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {stall, done, hilo_en} packed into the low bits for one compare.
  function automatic logic [31:0] ctl();
    return {29'b0, stall_o, done_o, hilo_en_o};
  endfunction

  task automatic do_div(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] elo, input logic [31:0] ehi);
    signed_i   = s;
    dividend_i = a;
    divisor_i  = b;
    annul_i    = 1'b0;
    start_i    = 1'b1;
    #1;
    check({tag, " ctl@accept"}, ctl(), 32'd4);
    for (int k = 1; k < lat; k++) begin
      tick();
      check({tag, " ctl stall"}, ctl(), 32'd4);
    end
    tick();
    check({tag, " ctl done"}, ctl(), 32'd3);
    check({tag, " lo"}, lo_o, elo);
    check({tag, " hi"}, hi_o, ehi);
    $display("[TB] %s: lo=%h hi=%h", tag, lo_o, hi_o);
    start_i = 1'b0;
    tick();
    check({tag, " ctl idle"}, ctl(), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    start_i    = 1'b0;
    signed_i   = 1'b0;
    annul_i    = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    tick();
    tick();
    check("reset ctl", ctl(), 32'd0);
    check("reset hi", hi_o, 32'd0);
    check("reset lo", lo_o, 32'd0);
    rst = 1'b0;
    tick();

    do_div("divu 100/7",     1'b0, 32'd100,        32'd7,          33, 32'd14,         32'd2);
    do_div("div -7/2",       1'b1, 32'hFFFF_FFF9,  32'd2,          33, 32'hFFFF_FFFD,  32'hFFFF_FFFF);
    do_div("divu fff9/2",    1'b0, 32'hFFFF_FFF9,  32'd2,          33, 32'h7FFF_FFFC,  32'd1);
    do_div("div 1234/0",     1'b1, 32'h0000_1234,  32'd0,          2,  32'hFFFF_FFFF,  32'h0000_1234);
    do_div("div min/-1",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  33, 32'h8000_0000,  32'd0);
    do_div("divu big",       1'b0, 32'hFFFF_FFFF,  32'h8000_0001,  33, 32'd1,          32'h7FFF_FFFE);
    do_div("div 7/-2",       1'b1, 32'd7,          32'hFFFF_FFFE,  33, 32'hFFFF_FFFD,  32'd1);

    // Annul during BUSY cycle 10
    signed_i   = 1'b0;
    dividend_i = 32'd1000;
    divisor_i  = 32'd3;
    start_i    = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check("annul busy ctl", ctl(), 32'd4);
    annul_i = 1'b1;
    #1;
    tick();
    annul_i = 1'b0;
    start_i = 1'b0;
    #1;
    check("annul idle ctl", ctl(), 32'd0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (hilo_en_o) pulses++;
    end
    check("annul no write", pulses, 0);
    check("annul lo held", lo_o, 32'hFFFF_FFFD);
    check("annul hi held", hi_o, 32'd1);
    $display("[TB] annul in BUSY: writes=%0d", pulses);
    do_div("divu 9/3 post-annul", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0);

    // Annul in IDLE blocks accept
    start_i = 1'b1;
    annul_i = 1'b1;
    #1;
    check("annul idle blocks stall", ctl(), 32'd0);
    tick();
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();
    check("annul idle not busy", ctl(), 32'd0);

    // Annul in DONE suppresses the write pulse
    dividend_i = 32'd5;
    divisor_i  = 32'd0;
    start_i    = 1'b1;
    tick();
    tick();
    annul_i = 1'b1;
    #1;
    check("annul done ctl", ctl(), 32'd0);
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    $display("[TB] annul in DONE: lo=%h hi=%h", lo_o, hi_o);

    // Reset in the middle of BUSY
    dividend_i = 32'd100;
    divisor_i  = 32'd7;
    start_i    = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    rst     = 1'b1;
    start_i = 1'b0;
    tick();
    check("rst busy ctl", ctl(), 32'd0);
    check("rst busy hi", hi_o, 32'd0);
    check("rst busy lo", lo_o, 32'd0);
    rst    = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (hilo_en_o) pulses++;
    end
    check("rst no write", pulses, 0);
    $display("[TB] reset mid-BUSY: writes=%0d", pulses);

    // Back-to-back with start held across DONE->IDLE
    signed_i   = 1'b0;
    dividend_i = 32'd100;
    divisor_i  = 32'd7;
    start_i    = 1'b1;
    pulses     = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (hilo_en_o) pulses++;
      if (k == 33) begin
        check("b2b first done", ctl(), 32'd3);
        check("b2b first lo", lo_o, 32'd14);
        check("b2b first hi", hi_o, 32'd2);
        dividend_i = 32'd9;
        divisor_i  = 32'd3;
      end
      if (k == 34) check("b2b re-accept stall", ctl(), 32'd4);
      if (k == 67) begin
        check("b2b second done", ctl(), 32'd3);
        check("b2b second lo", lo_o, 32'd3);
        check("b2b second hi", hi_o, 32'd0);
        start_i = 1'b0;
      end
    end
    check("b2b write count", pulses, 2);
    $display("[TB] back-to-back: writes=%0d", pulses);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
